hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//   Parametrised hazard/forwarding unit for the ARM pipeline. Tracks in-flight register writes
//   across DEPTH post-decode slots (slot 0 = EX ... slot DEPTH-1 = WB) in its own shift register.
//   Stalls ID on true RAW hazards. When forwarding is enabled, also issues registered operand-bypass
//   selects to EX. Adds load-use latency and a stall counter.
// PARAMETERS
//   REG_W      4   register-address width
//   DEPTH      3   tracked slots after ID; legal range >= 2 (EX..WB)
//   LOAD_READY 2   first slot index whose entry can bypass load data; range 1..DEPTH-1
//   CNT_W      16  stall-cycle counter width
// PORTS
//   clk         in   1              clock; all state updates on rising edge
//   rst         in   1              synchronous, active-high reset
//   forward_en  in   1              1 = bypass mode, 0 = stall-only mode
//   flush       in   1              branch taken in EX; kills ID instruction this cycle
//   id_valid    in   1              ID holds a real instruction
//   id_wb_en    in   1              ID instruction writes a register
//   id_mem_r_en in   1              ID instruction is a load
//   id_dest     in   REG_W          ID destination register
//   id_src1     in   REG_W          Rn
//   id_src1_use in   1              Rn is read
//   id_src2     in   REG_W          Rm/Rd (second source)
//   id_src2_use in   1              second source is read (TwoSrc)
//   stall       out  1              freeze PC/IF-reg; bubble into ID/EX (combinational)
//   fwd_sel1    out  $clog2(DEPTH)  EX bypass select for src1: 0 = regfile, k = slot k result
//   fwd_sel2    out  $clog2(DEPTH)  same for src2
//   stall_cnt   out  CNT_W          saturating count of stall cycles
// BEHAVIOUR
//   - Slot entry = {valid, wb_en, mem_r, dest}. Each cycle slot[k] <= slot[k-1].
//     slot[0] <= issue ? ID fields : all-zero bubble, where issue = id_valid & ~stall & ~flush.
//     Slot[DEPTH-1] falls off the end.
//   - Match(s,k): slot[k].valid & slot[k].wb_en & slot[k].dest==s, for used sources only, k in 0..DEPTH-2.
//     A match in slot DEPTH-1 is not a hazard: the regfile is write-before-read.
//   - Youngest match (lowest k) has priority per source.
//   - forward_en=0: stall = id_valid & ~flush & (any match for a used source).
//   - forward_en=1: the producer will sit at slot k+1 when the consumer reaches EX.
//       Load producer: stall if k+1 < LOAD_READY.
//       ALU producer: k+1 >= 1 always, so no stall.
//   - stall is forced 0 when flush=1 (flush wins) or id_valid=0.
//   - fwd_sel registered (1 cycle latency): on an issue cycle in bypass mode,
//     fwd_selN <= (youngest match k ? k+1 : 0).
//     Otherwise (no issue, or forward_en=0) fwd_selN <= 0.
//     Values align with the consumer's EX cycle.
//   - Sources with *_use=0 never match. R15/PC sources are not special-cased.
//   - stall_cnt increments on every cycle with stall=1 and holds at 2^CNT_W-1.
//   - Reset (any time, including mid-stall): all slots invalid; stall=0 (no matches);
//     fwd_sel1/2=0; stall_cnt=0. Takes effect the cycle after rst is sampled high.
//   - forward_en may change at any cycle; it takes effect on the same cycle's stall and on the next fwd_sel.
// STRUCTURE
//   - Shared package arm_pipe_pkg: slot_t struct {valid, wb_en, mem_r, dest}; FWD_REGFILE = 0 constant.
//   - One sub-module: hs_match, a per-source priority comparator (slots -> hit, youngest index, is_load).
//     Instantiated twice.
//   - Slot shift register, stall logic, select registers and counter live in the top module.
// TESTING  (DEPTH=3, LOAD_READY=2 unless noted)
//   - ALU chain, forward_en=1: ADD R1 then SUB R2,R1,R3 back-to-back
//     -> stall=0; fwd_sel1=1 in the SUB's EX cycle. Gap of 1 instruction -> fwd_sel1=2.
//   - Load-use, forward_en=1: LDR R4 then ADD R5,R4,R4
//     -> exactly 1 stall cycle; then fwd_sel1=fwd_sel2=2; stall_cnt=1.
//   - forward_en=0: ADD R1 then ORR R6,R1,R0
//     -> stall for 2 cycles, then issue with fwd_sel1=0; stall_cnt=2.
//   - Flush during stall: load-use hazard with flush=1 in the same cycle
//     -> stall=0, no issue, slot[0] bubble.
//   - Reset mid-operation: rst=1 while slots hold R1..R3 writers -> next cycle all slots empty;
//     a consumer of R1 gets stall=0, fwd_sel=0, stall_cnt=0.
//   - Saturation with CNT_W=4: hold a stall for 20 cycles -> stall_cnt stops at 15.
//     Also: a WB-slot-only match gives stall=0, fwd_sel=0.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared pipeline types: the per-slot in-flight write record and the bypass-select encoding.
package arm_pipe_pkg;

  // Holds any register address up to 8 bits; narrower addresses are zero-extended.
  localparam int SLOT_DEST_W = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                   valid;
    logic                   wb_en;
    logic                   mem_r;
    logic [SLOT_DEST_W-1:0] dest;
  } slot_t;

endpackage

// File: rtl/hs_match.sv
// Per-source priority comparator: finds the youngest in-flight writer of src among the
// hazard-relevant slots and reports whether that writer is a load.
module hs_match
  import arm_pipe_pkg::*;
#(
  parameter int N     = 2,
  parameter int SEL_W = 2
) (
  input  slot_t                  slots [N],
  input  logic [SLOT_DEST_W-1:0] src,
  input  logic                   src_use,
  output logic                   hit,
  output logic [SEL_W-1:0]       idx,
  output logic                   is_load
);

  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    // Oldest first, so the youngest match overwrites and wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (src_use && slots[k].valid && slots[k].wb_en && slots[k].dest == src) begin
        hit     = 1'b1;
        idx     = SEL_W'(k);
        is_load = slots[k].mem_r;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard / forwarding unit: tracks in-flight writes after ID, stalls ID on unresolved
// hazards (combinational), issues registered EX bypass selects and counts stall cycles.
module hazard_scoreboard
  import arm_pipe_pkg::*;
#(
  parameter int  REG_W      = 4,
  parameter int  DEPTH      = 3,
  parameter int  LOAD_READY = 2,
  parameter int  CNT_W      = 16,
  localparam int SEL_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic [REG_W-1:0] id_src1,
  input  logic             id_src1_use,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src2_use,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt
);

  // The WB slot never causes a hazard (write-before-read regfile), so only EX..DEPTH-2 are stored.
  localparam int NS = DEPTH - 1;

  slot_t            slot_q [NS];
  slot_t            slot_d [NS];
  logic             hit1, hit2, ld1, ld2;
  logic [SEL_W-1:0] idx1, idx2;
  logic             hz1, hz2, issue;
  logic [SEL_W-1:0] fwd_sel1_d, fwd_sel1_q, fwd_sel2_d, fwd_sel2_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  hs_match #(.N(NS), .SEL_W(SEL_W)) u_match1 (
    .slots   (slot_q),
    .src     (SLOT_DEST_W'(id_src1)),
    .src_use (id_src1_use),
    .hit     (hit1),
    .idx     (idx1),
    .is_load (ld1)
  );

  hs_match #(.N(NS), .SEL_W(SEL_W)) u_match2 (
    .slots   (slot_q),
    .src     (SLOT_DEST_W'(id_src2)),
    .src_use (id_src2_use),
    .hit     (hit2),
    .idx     (idx2),
    .is_load (ld2)
  );

  always_comb begin
    // A producer found at slot k is at slot k+1 when the consumer reaches EX.
    hz1   = hit1 && (!forward_en || (ld1 && (int'(idx1) + 1 < LOAD_READY)));
    hz2   = hit2 && (!forward_en || (ld2 && (int'(idx2) + 1 < LOAD_READY)));
    stall = id_valid && !flush && (hz1 || hz2);
    issue = id_valid && !stall && !flush;

    slot_d[0] = '0;
    if (issue) begin
      slot_d[0].valid = 1'b1;
      slot_d[0].wb_en = id_wb_en;
      slot_d[0].mem_r = id_mem_r_en;
      slot_d[0].dest  = SLOT_DEST_W'(id_dest);
    end
    for (int k = 1; k < NS; k++) slot_d[k] = slot_q[k-1];

    fwd_sel1_d = SEL_W'(FWD_REGFILE);
    fwd_sel2_d = SEL_W'(FWD_REGFILE);
    if (issue && forward_en && hit1) fwd_sel1_d = idx1 + SEL_W'(1);
    if (issue && forward_en && hit2) fwd_sel2_d = idx2 + SEL_W'(1);

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) slot_q[k] <= '0;
      fwd_sel1_q  <= '0;
      fwd_sel2_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      slot_q      <= slot_d;
      fwd_sel1_q  <= fwd_sel1_d;
      fwd_sel2_q  <= fwd_sel2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_sel1  = fwd_sel1_q;
  assign fwd_sel2  = fwd_sel2_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard (DEPTH=3, LOAD_READY=2, CNT_W=4): reference model plus a queue
// of expected bypass selects, with directed scenarios followed by a random phase.
module tb_hazard_scoreboard;

  localparam int DEPTH      = 3;
  localparam int LOAD_READY = 2;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       forward_en = 1'b1, flush = 1'b0, id_valid = 1'b0, id_wb_en = 1'b0, id_mem_r_en = 1'b0;
  logic [3:0] id_dest = '0, id_src1 = '0, id_src2 = '0;
  logic       id_src1_use = 1'b0, id_src2_use = 1'b0;
  logic       stall;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [CNT_W-1:0] stall_cnt;

  hazard_scoreboard #(.REG_W(4), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .flush(flush),
    .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .id_src1(id_src1), .id_src1_use(id_src1_use), .id_src2(id_src2), .id_src2_use(id_src2_use),
    .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; bit w; bit m; bit [3:0] d; } mslot_t;
  typedef struct { int s1; int s2; } exp_sel_t;

  mslot_t   ms [DEPTH];
  exp_sel_t fq [$];
  int       m_cnt;
  int       n_vec = 0, n_err = 0;
  int       obs_stall, obs_sel1, obs_sel2, obs_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Youngest hazard-relevant writer of s (WB slot excluded), or -1.
  function automatic int youngest(input bit [3:0] s, input bit u);
    if (!u) return -1;
    for (int k = 0; k <= DEPTH - 2; k++)
      if (ms[k].v && ms[k].w && ms[k].d == s) return k;
    return -1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) ms[k] = '{0, 0, 0, 4'd0};
    m_cnt = 0;
  endtask

  // One clock cycle: check registered outputs from the previous edge, drive ID, check stall.
  task automatic cyc(input bit v, input bit w, input bit ld, input bit [3:0] d,
                     input bit [3:0] s1, input bit u1, input bit [3:0] s2, input bit u2,
                     input bit fe = 1'b1, input bit fl = 1'b0, input bit r = 1'b0);
    exp_sel_t e;
    int k1, k2;
    bit haz, e_stall, iss;
    @(posedge clk);
    #1;
    if (fq.size() == 0) begin
      chk("fwd_queue_empty", 1, 0);
    end else begin
      e = fq.pop_front();
      chk("fwd_sel1", int'(fwd_sel1), e.s1);
      chk("fwd_sel2", int'(fwd_sel2), e.s2);
    end
    chk("stall_cnt", int'(stall_cnt), m_cnt);
    obs_sel1 = int'(fwd_sel1);
    obs_sel2 = int'(fwd_sel2);
    obs_cnt  = int'(stall_cnt);

    rst = r; forward_en = fe; flush = fl; id_valid = v; id_wb_en = w; id_mem_r_en = ld;
    id_dest = d; id_src1 = s1; id_src1_use = u1; id_src2 = s2; id_src2_use = u2;
    #1;

    k1 = youngest(s1, u1);
    k2 = youngest(s2, u2);
    haz = 1'b0;
    if (k1 >= 0) haz |= fe ? (ms[k1].m && (k1 + 1 < LOAD_READY)) : 1'b1;
    if (k2 >= 0) haz |= fe ? (ms[k2].m && (k2 + 1 < LOAD_READY)) : 1'b1;
    e_stall = v && !fl && haz;
    chk("stall", int'(stall), int'(e_stall));
    obs_stall = int'(stall);
    iss = v && !e_stall && !fl;

    if (r) begin
      model_clear();
      fq.push_back('{0, 0});
    end else begin
      e.s1 = (iss && fe && k1 >= 0) ? k1 + 1 : 0;
      e.s2 = (iss && fe && k2 >= 0) ? k2 + 1 : 0;
      fq.push_back(e);
      if (e_stall && m_cnt < CNT_MAX) m_cnt++;
      for (int k = DEPTH - 1; k > 0; k--) ms[k] = ms[k-1];
      ms[0] = iss ? '{1, w, ld, d} : '{0, 0, 0, 4'd0};
    end
  endtask

  task automatic nop(input bit fe = 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, fe);
  endtask

  task automatic rst_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    fq.push_back('{0, 0});
    repeat (2) @(posedge clk);

    // Reset state observed at the start of the first cycle.
    rst_cyc();
    chk("reset_cnt", obs_cnt, 0);

    // ALU chain back-to-back, then with one unrelated instruction in between.
    cyc(1, 1, 0, 4'd1, 0, 0, 0, 0);                 // ADD R1
    cyc(1, 1, 0, 4'd2, 4'd1, 1, 4'd3, 1);           // SUB R2,R1,R3
    chk("alu_b2b_stall", obs_stall, 0);
    nop();
    chk("alu_b2b_sel1", obs_sel1, 1);
    chk("alu_b2b_sel2", obs_sel2, 0);
    cyc(1, 1, 0, 4'd1, 0, 0, 0, 0);                 // ADD R1
    cyc(1, 1, 0, 4'd7, 0, 0, 0, 0);                 // MOV R7
    cyc(1, 1, 0, 4'd2, 4'd1, 1, 4'd3, 1);           // SUB R2,R1,R3
    nop();
    chk("alu_gap_sel1", obs_sel1, 2);

    // Load-use with bypass: one stall, then both operands from slot 2.
    rst_cyc();
    cyc(1, 1, 1, 4'd4, 0, 0, 0, 0);                 // LDR R4
    cyc(1, 1, 0, 4'd5, 4'd4, 1, 4'd4, 1);           // ADD R5,R4,R4
    chk("ld_use_stall", obs_stall, 1);
    cyc(1, 1, 0, 4'd5, 4'd4, 1, 4'd4, 1);
    chk("ld_use_issue", obs_stall, 0);
    nop();
    chk("ld_use_sel1", obs_sel1, 2);
    chk("ld_use_sel2", obs_sel2, 2);
    chk("ld_use_cnt", obs_cnt, 1);

    // Stall-only mode: two stalls, then issue reading the regfile.
    rst_cyc();
    cyc(1, 1, 0, 4'd1, 0, 0, 0, 0, 0);              // ADD R1
    cyc(1, 1, 0, 4'd6, 4'd1, 1, 4'd0, 1, 0);        // ORR R6,R1,R0
    chk("nofwd_stall_a", obs_stall, 1);
    cyc(1, 1, 0, 4'd6, 4'd1, 1, 4'd0, 1, 0);
    chk("nofwd_stall_b", obs_stall, 1);
    cyc(1, 1, 0, 4'd6, 4'd1, 1, 4'd0, 1, 0);
    chk("nofwd_issue", obs_stall, 0);
    nop();
    chk("nofwd_sel1", obs_sel1, 0);
    chk("nofwd_cnt", obs_cnt, 2);

    // Flush in the same cycle as a load-use hazard: no stall, no issue.
    rst_cyc();
    cyc(1, 1, 1, 4'd4, 0, 0, 0, 0);                 // LDR R4
    cyc(1, 1, 0, 4'd5, 4'd4, 1, 4'd4, 1, 1, 1);     // ADD R5 killed by flush
    chk("flush_stall", obs_stall, 0);
    cyc(1, 1, 0, 4'd8, 4'd5, 1, 0, 0, 0);           // reader of R5 sees no writer
    chk("flush_bubble", obs_stall, 0);

    // Reset while R1..R3 writers are in flight.
    cyc(1, 1, 0, 4'd1, 0, 0, 0, 0);
    cyc(1, 1, 0, 4'd2, 0, 0, 0, 0);
    cyc(1, 1, 0, 4'd3, 0, 0, 0, 0);
    rst_cyc();
    cyc(1, 1, 0, 4'd9, 4'd1, 1, 4'd3, 1, 0);        // stall-only consumer of R1,R3
    chk("rst_mid_stall", obs_stall, 0);
    chk("rst_mid_cnt_a", obs_cnt, 0);
    cyc(1, 1, 0, 4'd9, 4'd1, 1, 4'd2, 1, 1);
    nop();
    chk("rst_mid_sel1", obs_sel1, 0);
    chk("rst_mid_cnt_b", obs_cnt, 0);

    // Match only in the WB slot is not a hazard and is not bypassed.
    cyc(1, 1, 1, 4'd9, 0, 0, 0, 0);                 // LDR R9
    nop();
    nop();
    cyc(1, 1, 0, 4'd10, 4'd9, 1, 4'd9, 1, 1);
    chk("wb_only_stall", obs_stall, 0);
    nop();
    chk("wb_only_sel1", obs_sel1, 0);
    chk("wb_only_sel2", obs_sel2, 0);

    // Twenty stall cycles saturate the 4-bit counter at 15.
    rst_cyc();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, 4'd1, 0, 0, 0, 0, 0);
      repeat (3) cyc(1, 1, 0, 4'd6, 4'd1, 1, 4'd0, 0, 0);
    end
    nop();
    chk("sat_cnt", obs_cnt, CNT_MAX);

    // Random traffic against the model.
    rst_cyc();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          4'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end
    nop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
